// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin data-memory arbiter (core port 0, host port 1) with host burst lock.
// Optional range checking is compiled in with DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int DEPTH     = 64,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [AW-1:0]            m0_addr,
  input  logic [DW-1:0]            m0_wdata,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [DW-1:0]            m0_rdata,
  output logic                     core_stall,
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [AW-1:0]            m1_addr,
  input  logic [DW-1:0]            m1_wdata,
  input  logic                     m1_lock,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [DW-1:0]            m1_rdata,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     err
);
  localparam int LW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_BURST + 1);
`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif
  logic          rr_q, rr_d, lock_q, lock_d, err_q, err_d;
  logic          m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_win, gnt, we_g, oor;
  logic [AW-1:0] addr_g;
  logic [DW-1:0] rd;
  // The burst limit only bites while the core is actually waiting.
  assign lock_win   = lock_q & m1_req & ~(m0_req & (cnt_q == CW'(MAX_BURST)));
  assign m1_gnt     = ~rst & (lock_win | (m1_req & (~m0_req | rr_q)));
  assign m0_gnt     = ~rst & ~lock_win & m0_req & (~m1_req | ~rr_q);
  assign core_stall = m0_req & ~m0_gnt;
  assign gnt        = m0_gnt | m1_gnt;
  assign we_g       = m1_gnt ? m1_we : m0_we;
  assign addr_g     = m1_gnt ? m1_addr : m0_addr;
  assign oor        = RCHK & gnt & (|(addr_g >> LW));
  assign mem_we     = gnt & we_g & ~oor;
  assign mem_addr   = gnt ? addr_g[LW-1:0] : '0;
  assign mem_wdata  = m1_gnt ? m1_wdata : m0_wdata;
  assign rd         = oor ? '0 : mem_rdata;
  always_comb begin
    rr_d        = gnt ? m0_gnt : rr_q;
    lock_d      = m1_gnt & m1_lock;
    cnt_d       = (m0_gnt | ~lock_d) ? '0 :
                  (lock_q & m1_gnt & m0_req & (cnt_q != CW'(MAX_BURST))) ? cnt_q + 1'b1 : cnt_q;
    m0_rvalid_d = m0_gnt & ~m0_we;
    m1_rvalid_d = m1_gnt & ~m1_we;
    m0_rdata_d  = m0_rvalid_d ? rd : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? rd : m1_rdata_q;
    err_d       = oor;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      err_q       <= err_d;
    end
  end
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign err       = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural 64-word memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, core_stall;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_we, err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  int checks = 0, failures = 0, stalls;
`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif
  always #5 clk = ~clk;
  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .core_stall(core_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic drv(input logic r0, w0, input logic [31:0] a0, d0,
                     input logic r1, w1, input logic [31:0] a1, d1, input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
    #1;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask
  initial begin
    // reset with both ports requesting
    drv(1, 0, 5, 0, 1, 0, 7, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_g0_%0d", i), 32'(m0_gnt), 0);
      check($sformatf("rst_g1_%0d", i), 32'(m1_gnt), 0);
      check($sformatf("rst_we_%0d", i), 32'(mem_we), 0);
      cyc();
      check($sformatf("rst_rv0_%0d", i), 32'(m0_rvalid), 0);
      check($sformatf("rst_rv1_%0d", i), 32'(m1_rvalid), 0);
      check($sformatf("rst_err_%0d", i), 32'(err), 0);
    end
    check("rst_rd0", m0_rdata, 0);
    // core-only write then read
    rst = 1'b0;
    drv(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("c_wr_gnt", 32'(m0_gnt), 1);
    check("c_wr_stall", 32'(core_stall), 0);
    check("c_wr_we", 32'(mem_we), 1);
    check("c_wr_addr", 32'(mem_addr), 5);
    cyc();
    drv(1, 0, 5, 0, 0, 0, 0, 0, 0);
    check("c_rd_gnt", 32'(m0_gnt), 1);
    check("c_rd_stall", 32'(core_stall), 0);
    check("c_wr_rv", 32'(m0_rvalid), 0);
    cyc();
    check("c_rd_rv", 32'(m0_rvalid), 1);
    check("c_rd_data", m0_rdata, 32'hDEADBEEF);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("c_rv_pulse", 32'(m0_rvalid), 0);
    // round-robin conflict
    do_reset();
    drv(1, 0, 5, 0, 1, 0, 5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_g0_%0d", i), 32'(m0_gnt), (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_g1_%0d", i), 32'(m1_gnt), (i % 2 == 1) ? 1 : 0);
      check($sformatf("rr_stall_%0d", i), 32'(core_stall), (i % 2 == 1) ? 1 : 0);
      cyc();
      check($sformatf("rr_rv0_%0d", i), 32'(m0_rvalid), (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_rv1_%0d", i), 32'(m1_rvalid), (i % 2 == 1) ? 1 : 0);
    end
    check("rr_rd1", m1_rdata, 32'hDEADBEEF);
    // host burst lock, limit 8
    do_reset();
    drv(0, 0, 0, 0, 1, 0, 1, 0, 1);
    check("bl_first", 32'(m1_gnt), 1);
    cyc();
    drv(1, 0, 2, 0, 1, 0, 1, 0, 1);
    stalls = 0;
    for (int i = 0; i < 9; i++) begin
      stalls += int'(core_stall);
      check($sformatf("bl_stall_%0d", i), 32'(core_stall), (i < 8) ? 1 : 0);
      check($sformatf("bl_g1_%0d", i), 32'(m1_gnt), (i < 8) ? 1 : 0);
      check($sformatf("bl_g0_%0d", i), 32'(m0_gnt), (i == 8) ? 1 : 0);
      cyc();
    end
    check("bl_stalls", 32'(stalls), 8);
    // reset in the middle of a locked host write burst
    do_reset();
    drv(0, 0, 0, 0, 1, 1, 10, 32'h11, 1);
    cyc();
    drv(1, 0, 10, 0, 1, 1, 10, 32'h11, 1);
    check("mb_locked", 32'(m1_gnt), 1);
    cyc();
    cyc();
    rst = 1'b1;
    drv(1, 0, 10, 0, 1, 1, 10, 32'h99, 1);
    check("mb_rst_we", 32'(mem_we), 0);
    check("mb_rst_g1", 32'(m1_gnt), 0);
    cyc();
    rst = 1'b0;
    drv(1, 0, 10, 0, 1, 0, 10, 0, 0);
    check("mb_post_g0", 32'(m0_gnt), 1);
    check("mb_post_g1", 32'(m1_gnt), 0);
    cyc();
    check("mb_rv", 32'(m0_rvalid), 1);
    check("mb_data", m0_rdata, 32'h11);
    // out-of-range host write
    do_reset();
    drv(1, 1, 0, 32'h5555, 0, 0, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 1, 1, 64, 32'h1234, 0);
    check("oor_gnt", 32'(m1_gnt), 1);
    check("oor_we", 32'(mem_we), RCHK ? 0 : 1);
    cyc();
    check("oor_err", 32'(err), RCHK ? 1 : 0);
    drv(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc();
    check("oor_rv", 32'(m1_rvalid), 1);
    check("oor_data", m1_rdata, RCHK ? 32'h5555 : 32'h1234);
    check("oor_err_clr", 32'(err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
